// File: rtl/reg_bus_master.sv
// Register-bus initiator: one command at a time in, bus cycles out, response back.
// Define REG_BUS_MASTER_RMW_EN to build read-modify-write (op 10); otherwise op 10 is rejected.
module reg_bus_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic                cmd_fire;
  logic                cmd_bad;
  logic                rmw_ok;
  logic [DATA_W-1:0]   wr_word;

`ifdef REG_BUS_MASTER_RMW_EN
  logic [DATA_W-1:0]   mask_q;

  assign rmw_ok = 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (cmd_fire) begin
      mask_q <= cmd_mask;
    end
  end

  assign wr_word = (op_q == OP_RMW) ? ((data_q & ~mask_q) | (wdata_q & mask_q)) : wdata_q;
`else
  logic unused_mask;

  assign rmw_ok      = 1'b0;
  assign unused_mask = ^cmd_mask;
  assign wr_word     = wdata_q;
`endif

  assign cmd_fire = cmd_valid && (state == IDLE);
  // Misaligned, reserved or not-built ops go straight to the response with no bus cycle.
  assign cmd_bad  = (cmd_addr[1:0] != 2'b00) || (cmd_op == OP_RSVD) ||
                    ((cmd_op == OP_RMW) && !rmw_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            state_next = RSP;
          end else if (cmd_op == OP_WRITE) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = ((op_q == OP_RMW) && rmw_ok) ? WR : RSP;
      WR:      state_next = RSP;
      RSP:     state_next = rsp_ready ? IDLE : RSP;
      default: state_next = IDLE;
    endcase
  end

  // data_q is cleared on accept so WRITE and rejected commands report 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        data_q  <= '0;
        err_q   <= cmd_bad;
      end
      if (state == RD) begin
        data_q <= rdata;
      end
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr      = '0;
    wdata     = '0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      RD: begin
        rd_en = 1'b1;
        addr  = addr_q;
      end
      WR: begin
        wr_en = 1'b1;
        addr  = addr_q;
        wdata = wr_word;
      end
      RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = data_q;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule
